// File: rtl/ysyx_22040632_dcache_wb_if.sv
// AXI4 write-channel bundle (AW/W/B) between the dcache write-back engine and the AXI write master.
// Latency: none, wires only.
// Backpressure: plain valid/ready per channel; the master holds payloads until ready.
interface ysyx_22040632_dcache_wb_if #(
    parameter int ADDR_W = 32
);
    logic              awvalid;
    logic              awready;
    logic [ADDR_W-1:0] awaddr;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic              wvalid;
    logic              wready;
    logic [63:0]       wdata;
    logic [7:0]        wstrb;
    logic              wlast;
    logic              bvalid;
    logic              bready;
    logic [1:0]        bresp;

    modport master (
        output awvalid, awaddr, awlen, awsize, awburst,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bresp,
        output bready
    );

    modport slave (
        input  awvalid, awaddr, awlen, awsize, awburst,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bresp,
        input  bready
    );
endinterface

// File: rtl/ysyx_22040632_dcache_wb.sv
// Dcache victim-line write-back: reads a 64-byte line from one way into a buffer, then sends it as one 8-beat AXI4 INCR burst.
// Latency: AW valid 6 cycles after wb_start; done pulse 16 cycles after wb_start when all ready/valid inputs are high.
// Backpressure: AW and W payloads held while awready/wready are low; bready held until bvalid; wb_start ignored while busy.
module ysyx_22040632_dcache_wb #(
    parameter int ADDR_W     = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic              clk,
    input  logic              rrst,
    input  logic              wb_start,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic              wb_way,
    output logic              busy,
    output logic              done,
    output logic              resp_err,
    output logic              rd_en,
    output logic [1:0]        rd_addr_inside,
    input  logic [127:0]      rd_data_1stway,
    input  logic [127:0]      rd_data_2ndway,
    ysyx_22040632_dcache_wb_if.master axi
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] READ = 3'd1;
    localparam logic [2:0] ADDR = 3'd2;
    localparam logic [2:0] DATA = 3'd3;
    localparam logic [2:0] RESP = 3'd4;

    logic [2:0]        state;
    logic [2:0]        rc;
    logic [2:0]        bc;
    logic [ADDR_W-7:0] line_tag;
    logic              way;
    logic [127:0]      line_buf [LINE_WORDS];
    logic [127:0]      cur_word;
    logic              reading;
    logic              unused_addr_bits;

    // Offset bits within the line are dropped: the burst always covers the whole line.
    assign unused_addr_bits = ^wb_addr[5:0];

    // The array is addressed for the first LINE_WORDS cycles of READ; the last cycle only captures.
    assign reading        = (state == READ) && (rc < 3'(LINE_WORDS));
    assign rd_en          = reading;
    assign rd_addr_inside = reading ? rc[1:0] : 2'b00;
    assign busy           = (state != IDLE);

    // Beat bc carries the low half of word bc/2 first, then its high half.
    assign cur_word    = line_buf[bc[2:1]];
    assign axi.awvalid = (state == ADDR);
    assign axi.awaddr  = {line_tag, 6'b0};
    assign axi.awlen   = 8'd7;
    assign axi.awsize  = 3'b011;
    assign axi.awburst = 2'b01;
    assign axi.wvalid  = (state == DATA);
    assign axi.wdata   = bc[0] ? cur_word[127:64] : cur_word[63:0];
    assign axi.wstrb   = 8'hFF;
    assign axi.wlast   = (state == DATA) && (bc == 3'd7);
    assign axi.bready  = (state == RESP);

    // Control FSM, counters and completion status.
    always_ff @(posedge clk) begin
        if (rrst) begin
            state    <= IDLE;
            rc       <= 3'd0;
            bc       <= 3'd0;
            resp_err <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (wb_start) begin
                        resp_err <= 1'b0;
                        rc       <= 3'd0;
                        bc       <= 3'd0;
                        state    <= READ;
                    end
                end
                READ: begin
                    if (rc == 3'(LINE_WORDS)) begin
                        rc    <= 3'd0;
                        state <= ADDR;
                    end else begin
                        rc <= rc + 3'd1;
                    end
                end
                ADDR: begin
                    if (axi.awready) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (axi.wready) begin
                        bc <= bc + 3'd1;
                        if (bc == 3'd7) begin
                            state <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (axi.bvalid) begin
                        resp_err <= (axi.bresp != 2'b00);
                        done     <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Request latch and line buffer; the array data lands one cycle after each read strobe.
    always_ff @(posedge clk) begin
        if (state == IDLE && wb_start) begin
            line_tag <= wb_addr[ADDR_W-1:6];
            way      <= wb_way;
        end
        if (state == READ && rc != 3'd0) begin
            line_buf[2'(rc - 3'd1)] <= way ? rd_data_2ndway : rd_data_1stway;
        end
    end

endmodule

// File: tb/tb_ysyx_22040632_dcache_wb.sv
// Self-checking bench for the dcache write-back engine against a line-level reference model.
// Latency: checks start-to-AW, start-to-done and back-to-back acceptance timing.
// Backpressure: drives AW/W stalls and checks payload stability and handshake count.
module tb_ysyx_22040632_dcache_wb;
    logic         clk = 1'b0;
    logic         rrst;
    logic         wb_start;
    logic [31:0]  wb_addr;
    logic         wb_way;
    logic         busy, done, resp_err, rd_en;
    logic [1:0]   rd_addr_inside;
    logic [127:0] rd_data_1stway, rd_data_2ndway;

    ysyx_22040632_dcache_wb_if #(.ADDR_W(32)) axi ();

    ysyx_22040632_dcache_wb #(.ADDR_W(32), .LINE_WORDS(4)) dut (
        .clk(clk), .rrst(rrst), .wb_start(wb_start), .wb_addr(wb_addr), .wb_way(wb_way),
        .busy(busy), .done(done), .resp_err(resp_err), .rd_en(rd_en),
        .rd_addr_inside(rd_addr_inside), .rd_data_1stway(rd_data_1stway),
        .rd_data_2ndway(rd_data_2ndway), .axi(axi)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Data array model: two ways of four 128-bit words, one-cycle read latency.
    logic [127:0] mem [2][4];
    always @(posedge clk) begin
        if (rd_en) begin
            rd_data_1stway <= mem[0][rd_addr_inside];
            rd_data_2ndway <= mem[1][rd_addr_inside];
        end
    end

    int checks = 0;
    int failures = 0;

    // Results collected by the burst driver.
    int          r_first_rd, r_rd_cnt, r_aw_first, r_aw_hs, r_done, r_overlap;
    int          r_aw_unstable, r_w_unstable, r_nbeats, r_strb_bad, r_busy_bad;
    bit          r_timeout, r_aborted;
    logic [31:0] r_awaddr;
    logic [7:0]  r_awlen, r_wlast_mask;
    logic [2:0]  r_awsize;
    logic [1:0]  r_awburst;
    logic        r_resp_err, r_busy_at_done, r_err_c1;
    logic [6:0]  r_ab_vals;
    logic [63:0] r_beats [$];
    logic [63:0] exp_q [$];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference model: a line is eight 64-bit beats, low half of each word first.
    task automatic snap(input bit way);
        logic [127:0] w;
        exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            w = mem[way][i / 2];
            exp_q.push_back((i % 2) ? w[127:64] : w[63:0]);
        end
    endtask

    task automatic scramble;
        for (int w = 0; w < 2; w++)
            for (int i = 0; i < 4; i++)
                mem[w][i] = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // Drives one write-back and plays the AXI slave; w_mode 0=always ready, 1=toggle, 2=random.
    task automatic do_burst(input bit way, input logic [31:0] addr, input int aw_delay,
                            input int w_mode, input logic [1:0] br, input bit pre_started,
                            input int start_beat, input int rst_beat, input bit chain,
                            input bit nway, input logic [31:0] naddr);
        int t0, c, aw_wait;
        bit have_aw, have_w, toggle;
        logic [31:0] hold_aw;
        logic [63:0] hold_w;
        r_first_rd = -1; r_rd_cnt = 0; r_aw_first = -1; r_aw_hs = -1; r_done = -1;
        r_overlap = 0; r_aw_unstable = 0; r_w_unstable = 0; r_nbeats = 0; r_strb_bad = 0;
        r_busy_bad = 0; r_timeout = 0; r_aborted = 0; r_wlast_mask = 0; r_err_c1 = 1'bx;
        r_beats.delete();
        aw_wait = 0; have_aw = 0; have_w = 0; toggle = 1;
        if (!pre_started) begin
            wb_start = 1; wb_addr = addr; wb_way = way;
        end
        t0 = cyc;
        tick();
        wb_start = 0;
        for (int k = 0; k < 300; k++) begin
            c = cyc - t0;
            axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = 2'b00; wb_start = 0;
            if (c == 1) r_err_c1 = resp_err;
            if (rd_en) begin
                if (r_first_rd < 0) r_first_rd = c;
                r_rd_cnt++;
            end
            if (done) begin
                r_done = c; r_resp_err = resp_err; r_busy_at_done = busy;
                if (chain) begin
                    wb_start = 1; wb_addr = naddr; wb_way = nway;
                end
                return;
            end
            if (!busy) r_busy_bad++;
            if (axi.awvalid && axi.wvalid) r_overlap++;
            if (axi.awvalid) begin
                if (r_aw_first < 0) r_aw_first = c;
                if (have_aw && axi.awaddr !== hold_aw) r_aw_unstable++;
                hold_aw = axi.awaddr; have_aw = 1;
                axi.awready = (aw_wait >= aw_delay);
                aw_wait++;
                if (axi.awready) begin
                    r_aw_hs = c; r_awaddr = axi.awaddr; r_awlen = axi.awlen;
                    r_awsize = axi.awsize; r_awburst = axi.awburst;
                    scramble();
                end
            end
            if (axi.wvalid) begin
                if (rst_beat >= 0 && r_nbeats == rst_beat) begin
                    rrst = 1;
                    tick();
                    r_ab_vals = {axi.awvalid, axi.wvalid, axi.bready, rd_en, busy, done, axi.wlast};
                    rrst = 0;
                    r_aborted = 1;
                    return;
                end
                if (have_w && axi.wdata !== hold_w) r_w_unstable++;
                if (axi.wstrb !== 8'hFF) r_strb_bad++;
                case (w_mode)
                    0: axi.wready = 1;
                    1: begin axi.wready = toggle; toggle = !toggle; end
                    default: axi.wready = 1'($urandom_range(0, 1));
                endcase
                if (axi.wready) begin
                    r_beats.push_back(axi.wdata);
                    if (axi.wlast && r_nbeats < 8) r_wlast_mask[r_nbeats] = 1'b1;
                    r_nbeats++;
                    have_w = 0;
                end else begin
                    hold_w = axi.wdata; have_w = 1;
                end
                if (start_beat >= 0 && r_nbeats == start_beat) begin
                    wb_start = 1; wb_addr = addr ^ 32'h0000_1000; wb_way = !way;
                end
            end
            if (axi.bready) begin
                axi.bvalid = 1; axi.bresp = br;
            end
            tick();
        end
        r_timeout = 1;
        rrst = 1;
        tick();
        rrst = 0;
    endtask

    task automatic test_reset;
        rrst = 1;
        tick(); tick();
        checks++;
        if ({busy, done, resp_err, rd_en} !== 4'b0)
            $display("FAIL reset_status busy/done/err/rd_en=%b expected 0000", {busy, done, resp_err, rd_en});
        checks++;
        if ({axi.awvalid, axi.wvalid, axi.wlast, axi.bready} !== 4'b0)
            $display("FAIL reset_axi aw/w/wlast/b=%b expected 0000", {axi.awvalid, axi.wvalid, axi.wlast, axi.bready});
        checks++;
        if (rd_addr_inside !== 2'b00) $display("FAIL reset_rd_addr got %0d expected 0", rd_addr_inside);
        failures += (({busy, done, resp_err, rd_en} !== 4'b0) ? 1 : 0)
                  + (({axi.awvalid, axi.wvalid, axi.wlast, axi.bready} !== 4'b0) ? 1 : 0)
                  + ((rd_addr_inside !== 2'b00) ? 1 : 0);
        rrst = 0;
        tick();
    endtask

    task automatic test_way0;
        logic [127:0] w;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 16; j++) w[j*8 +: 8] = 8'(i * 16 + j);
            mem[0][i] = w;
            mem[1][i] = {$urandom, $urandom, $urandom, $urandom};
        end
        snap(0);
        do_burst(0, 32'h8000_1234, 0, 0, 2'b00, 0, -1, -1, 0, 0, 0);
        checks++; if (r_timeout) begin failures++; $display("FAIL way0_timeout"); end
        checks++; if (r_awaddr !== 32'h8000_1200) begin failures++; $display("FAIL way0_awaddr got %h expected 80001200", r_awaddr); end
        checks++; if ({r_awlen, r_awsize, r_awburst} !== {8'd7, 3'b011, 2'b01}) begin
            failures++; $display("FAIL way0_awattr len=%0d size=%0d burst=%0d expected 7/3/1", r_awlen, r_awsize, r_awburst); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (i >= r_beats.size()) begin failures++; $display("FAIL way0_beat%0d missing expected %h", i, exp_q[i]); end
            else if (r_beats[i] !== exp_q[i]) begin failures++; $display("FAIL way0_beat%0d got %h expected %h", i, r_beats[i], exp_q[i]); end
        end
        checks++; if (r_wlast_mask !== 8'h80) begin failures++; $display("FAIL way0_wlast mask=%h expected 80", r_wlast_mask); end
        checks++; if (r_first_rd != 1 || r_rd_cnt != 4) begin failures++; $display("FAIL way0_rd first=%0d cnt=%0d expected 1/4", r_first_rd, r_rd_cnt); end
        checks++; if (r_aw_first != 6 || r_aw_hs != 6) begin failures++; $display("FAIL way0_aw_time first=%0d hs=%0d expected 6/6", r_aw_first, r_aw_hs); end
        checks++; if (r_done != 16) begin failures++; $display("FAIL way0_done_time got %0d expected 16", r_done); end
        checks++; if (r_resp_err !== 1'b0 || r_busy_at_done !== 1'b0) begin
            failures++; $display("FAIL way0_done_status err=%b busy=%b expected 0/0", r_resp_err, r_busy_at_done); end
        checks++; if (r_overlap != 0 || r_busy_bad != 0 || r_strb_bad != 0) begin
            failures++; $display("FAIL way0_protocol overlap=%0d busy_bad=%0d strb_bad=%0d expected 0", r_overlap, r_busy_bad, r_strb_bad); end
        tick();
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL way0_done_pulse done=%b one cycle later expected 0", done); end
    endtask

    task automatic test_way1;
        logic [31:0] a;
        for (int i = 0; i < 4; i++) begin
            mem[0][i] = '1;
            mem[1][i] = {$urandom, $urandom, $urandom, $urandom};
        end
        a = $urandom;
        snap(1);
        do_burst(1, a, 0, 0, 2'b00, 0, -1, -1, 0, 0, 0);
        checks++; if (r_timeout) begin failures++; $display("FAIL way1_timeout"); end
        checks++; if (r_awaddr !== {a[31:6], 6'b0}) begin failures++; $display("FAIL way1_awaddr got %h expected %h", r_awaddr, {a[31:6], 6'b0}); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (i >= r_beats.size() || r_beats[i] !== exp_q[i]) begin
                failures++; $display("FAIL way1_beat%0d expected %h", i, exp_q[i]); end
        end
    endtask

    task automatic test_stall;
        scramble();
        snap(0);
        do_burst(0, 32'h1234_5678, 5, 1, 2'b00, 0, -1, -1, 0, 0, 0);
        checks++; if (r_timeout) begin failures++; $display("FAIL stall_timeout"); end
        checks++; if (r_aw_first != 6 || r_aw_hs != 11) begin failures++; $display("FAIL stall_aw_time first=%0d hs=%0d expected 6/11", r_aw_first, r_aw_hs); end
        checks++; if (r_aw_unstable != 0 || r_w_unstable != 0) begin
            failures++; $display("FAIL stall_stability aw_changes=%0d w_changes=%0d expected 0", r_aw_unstable, r_w_unstable); end
        checks++; if (r_nbeats != 8 || r_wlast_mask !== 8'h80) begin
            failures++; $display("FAIL stall_beats count=%0d wlast=%h expected 8/80", r_nbeats, r_wlast_mask); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (i >= r_beats.size() || r_beats[i] !== exp_q[i]) begin
                failures++; $display("FAIL stall_beat%0d expected %h", i, exp_q[i]); end
        end
        checks++; if (r_overlap != 0) begin failures++; $display("FAIL stall_overlap got %0d expected 0", r_overlap); end
    endtask

    task automatic test_resp_err;
        do_burst(0, 32'h4000_0040, 0, 0, 2'b10, 0, -1, -1, 0, 0, 0);
        checks++; if (r_resp_err !== 1'b1) begin failures++; $display("FAIL resp_err_set got %b expected 1", r_resp_err); end
        tick();
        checks++; if (resp_err !== 1'b1) begin failures++; $display("FAIL resp_err_hold got %b expected 1", resp_err); end
        do_burst(1, 32'h4000_0080, 0, 2, 2'b00, 0, -1, -1, 0, 0, 0);
        checks++; if (r_err_c1 !== 1'b0) begin failures++; $display("FAIL resp_err_clear got %b expected 0", r_err_c1); end
        checks++; if (r_resp_err !== 1'b0) begin failures++; $display("FAIL resp_err_okay got %b expected 0", r_resp_err); end
    endtask

    task automatic test_ignore_start;
        int extra;
        scramble();
        snap(1);
        do_burst(1, 32'h2000_0100, 0, 0, 2'b00, 0, 3, -1, 0, 0, 0);
        checks++; if (r_awaddr !== 32'h2000_0100 || r_nbeats != 8) begin
            failures++; $display("FAIL ignore_burst addr=%h beats=%0d expected 20000100/8", r_awaddr, r_nbeats); end
        checks++; if (r_beats.size() != 8 || r_beats[3] !== exp_q[3] || r_beats[7] !== exp_q[7]) begin
            failures++; $display("FAIL ignore_data beats=%0d expected unchanged line", r_beats.size()); end
        extra = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (rd_en || axi.awvalid || busy) extra++;
        end
        checks++; if (extra != 0) begin failures++; $display("FAIL ignore_extra active_cycles=%0d expected 0", extra); end
    endtask

    task automatic test_reset_mid;
        int seen_done;
        do_burst(0, 32'h3000_0000, 0, 0, 2'b00, 0, -1, 3, 0, 0, 0);
        checks++; if (!r_aborted) begin failures++; $display("FAIL rst_mid_not_reached"); end
        checks++; if (r_ab_vals !== 7'b0) begin failures++; $display("FAIL rst_mid_outputs aw/w/b/rd/busy/done/wlast=%b expected 0", r_ab_vals); end
        seen_done = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done || busy) seen_done++;
        end
        checks++; if (seen_done != 0) begin failures++; $display("FAIL rst_mid_quiet cycles=%0d expected 0", seen_done); end
        scramble();
        snap(1);
        do_burst(1, 32'h3000_0400, 0, 0, 2'b00, 0, -1, -1, 0, 0, 0);
        checks++; if (r_done != 16) begin failures++; $display("FAIL rst_mid_fresh_done got %0d expected 16", r_done); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (i >= r_beats.size() || r_beats[i] !== exp_q[i]) begin
                failures++; $display("FAIL rst_mid_beat%0d expected %h", i, exp_q[i]); end
        end
    endtask

    task automatic test_back_to_back;
        scramble();
        snap(0);
        do_burst(0, 32'h5000_0000, 0, 0, 2'b00, 0, -1, -1, 1, 1, 32'h5000_0FC0);
        checks++; if (r_done != 16) begin failures++; $display("FAIL b2b_first_done got %0d expected 16", r_done); end
        snap(1);
        do_burst(1, 32'h5000_0FC0, 0, 0, 2'b00, 1, -1, -1, 0, 0, 0);
        checks++; if (r_first_rd != 1) begin failures++; $display("FAIL b2b_rd_rise got %0d expected 1", r_first_rd); end
        checks++; if (r_awaddr !== 32'h5000_0FC0 || r_done != 16) begin
            failures++; $display("FAIL b2b_second addr=%h done=%0d expected 50000fc0/16", r_awaddr, r_done); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (i >= r_beats.size() || r_beats[i] !== exp_q[i]) begin
                failures++; $display("FAIL b2b_beat%0d expected %h", i, exp_q[i]); end
        end
    endtask

    task automatic test_random;
        bit way;
        logic [31:0] a;
        logic [1:0] br;
        int bad;
        for (int n = 0; n < 20; n++) begin
            scramble();
            way = 1'($urandom_range(0, 1));
            a = $urandom;
            br = 2'($urandom_range(0, 3));
            snap(way);
            do_burst(way, a, $urandom_range(0, 3), 2, br, 0, -1, -1, 0, 0, 0);
            bad = 0;
            for (int i = 0; i < 8; i++)
                if (i >= r_beats.size() || r_beats[i] !== exp_q[i]) bad++;
            checks++; if (bad != 0) begin failures++; $display("FAIL rand%0d_data wrong_beats=%0d expected 0", n, bad); end
            checks++; if (r_awaddr !== {a[31:6], 6'b0}) begin failures++; $display("FAIL rand%0d_awaddr got %h expected %h", n, r_awaddr, {a[31:6], 6'b0}); end
            checks++; if (r_resp_err !== (br != 2'b00)) begin failures++; $display("FAIL rand%0d_resp_err got %b expected %b", n, r_resp_err, br != 2'b00); end
            checks++; if (r_wlast_mask !== 8'h80 || r_overlap != 0 || r_w_unstable != 0) begin
                failures++; $display("FAIL rand%0d_protocol wlast=%h overlap=%0d w_changes=%0d", n, r_wlast_mask, r_overlap, r_w_unstable); end
        end
    endtask

    initial begin
        rrst = 1; wb_start = 0; wb_addr = 0; wb_way = 0;
        axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = 0;
        rd_data_1stway = 0; rd_data_2ndway = 0;
        for (int w = 0; w < 2; w++)
            for (int i = 0; i < 4; i++) mem[w][i] = '0;
        test_reset();
        test_way0();
        test_way1();
        test_stall();
        test_resp_err();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ysyx_22040632_dcache_wb.md
Name: ysyx_22040632_dcache_wb

Overview:
Dcache write-back (eviction) engine: the read-out path of the dcache data array, i.e. the reverse of the AXI refill path. On a start pulse it reads a victim 64-byte line (four 128-bit words) from one way of the data array into a line buffer. It then transmits the line as one AXI4 INCR burst of eight 64-bit beats on AW/W and completes on the B response. It sits between the dcache controller FSM and the AXI write master port.

Parameters:
ADDR_W, 32, AXI address width
LINE_WORDS, 4, 128-bit words per line; beats per burst = 2*LINE_WORDS (fixed 8 in this revision)

Ports:
clk  in  1  clock; all logic is rising-edge
rrst  in  1  reset, synchronous, active-high
wb_start  in  1  one-cycle pulse: begin write-back; ignored unless idle
wb_addr  in  ADDR_W  victim line address; bits [5:0] ignored
wb_way  in  1  victim way (0 = first way, 1 = second way)
busy  out  1  engine active
done  out  1  one-cycle pulse: write-back finished
resp_err  out  1  last burst got a non-OKAY BRESP
rd_en  out  1  data array read strobe
rd_addr_inside  out  2  word select within the line (drives addr_inside[5:4])
rd_data_1stway  in  128  array output, first way, valid 1 cycle after rd_en
rd_data_2ndway  in  128  array output, second way, valid 1 cycle after rd_en
awvalid  out  1 / awready  in  1 / awaddr  out  ADDR_W / awlen  out  8 / awsize  out  3 / awburst  out  2
wvalid  out  1 / wready  in  1 / wdata  out  64 / wstrb  out  8 / wlast  out  1
bvalid  in  1 / bready  out  1 / bresp  in  2

Behaviour:
- Reset (rrst=1 at a clk edge): state IDLE. busy, done, resp_err, rd_en, awvalid, wvalid, wlast and bready are 0. rd_addr_inside=0; counters=0. Reset mid-burst aborts immediately with all valids dropped; no completion is signalled.
- States: IDLE -> READ -> ADDR -> DATA -> RESP -> IDLE.
- IDLE: on wb_start, latch {wb_addr[ADDR_W-1:6],6'b0} and wb_way, clear resp_err, and go to READ. wb_start outside IDLE is ignored.
- READ: a 3-bit counter rc runs 0..4.
  - rd_en=1 and rd_addr_inside=rc while rc<4.
  - At rc=1..4, the selected way's rd_data is captured into buffer word rc-1.
  - After rc=4 go to ADDR. READ lasts exactly 5 cycles.
- ADDR: awvalid=1, awaddr=latched line address, awlen=8'd7, awsize=3'b011, awburst=2'b01. These values are held stable until awready. Handshake (awvalid&&awready) -> DATA.
- DATA: wvalid=1, wstrb=8'hFF.
  - wdata = buffer word[bc[2:1]], low 64 bits when bc[0]=0, high 64 bits when bc[0]=1.
  - bc is a 3-bit beat counter; wlast=(bc==7).
  - bc increments only on the wvalid&&wready handshake; data is held while wready=0.
  - Handshake with bc==7 -> RESP.
- RESP: bready=1. On bvalid: resp_err <= (bresp!=2'b00), go to IDLE, and done=1 for the next cycle only.
- busy=1 in every non-IDLE state; busy=0 in the cycle done is high.
- Timing: wb_start at cycle T gives rd_en high during T+1..T+4 and awvalid first high at T+6. With awready, wready and bvalid tied high: AW handshake at T+6, W beats at T+7..T+14, B handshake at T+15, done at T+16.
- A new wb_start in the done cycle is accepted (state is IDLE).
- awvalid and wvalid are never both high; W starts only after the AW handshake.
- Buffer words are not modified after READ; the array may change after READ without affecting the burst.

Test Plan:
- Way 0, wb_addr=32'h8000_1234, first-way words W0..W3 = 128'h...0F_00 ... 128'h...3F_30 patterns, all ready=1 -> awaddr=32'h8000_1200, awlen=7; wdata = W0[63:0], W0[127:64], ..., W3[127:64]; wlast only on beat 8; done at T+16, resp_err=0.
- Way 1 with distinct 2nd-way data, and the first way driven to all 1s -> only 2nd-way data appears on wdata.
- awready held low 5 cycles, then wready toggled 1-0-1-0 -> awaddr/wdata stable while stalled; exactly 8 W handshakes; wlast on the 8th.
- bresp=2'b10 -> resp_err=1 with done. A next wb_start clears resp_err; that burst's OKAY response leaves resp_err=0.
- wb_start pulsed during DATA -> ignored, single burst only. rrst asserted at beat 3 -> next cycle all valids=0, busy=0, no done; a fresh wb_start then completes normally.
- wb_start in the done cycle -> rd_en rises the next cycle; back-to-back bursts complete correctly.
